// File: rtl/serial_adder_mux_if.sv
// Handshake/operand bundle for serial_adder_mux; the sub/ovf signals exist only
// when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_mux_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_mux.sv
// Bit-serial LSB-first adder built on one mux-form full-adder cell; WIDTH+1 cycles per result.
// Optional subtract/overflow support is enabled with SERIAL_ADDER_SUB_EN.
module serial_adder_mux #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_mux_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
`ifdef SERIAL_ADDER_SUB_EN
    logic             ovf_reg;

    // Subtraction is a + ~b + 1: invert B on load and force the carry FF to 1.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_load = bus.sub ? 1'b1 : bus.cin;
    assign bus.ovf    = ovf_reg;
`else
    assign b_load     = bus.b;
    assign carry_load = bus.cin;
`endif

    always_comb begin
        s_bit = 1'b0;
        c_bit = 1'b0;
        if (b_sh_reg[0]) begin
            s_bit = a_sh_reg[0] ? carry_reg : ~carry_reg;
            c_bit = a_sh_reg[0] ? 1'b1 : carry_reg;
        end else begin
            s_bit = a_sh_reg[0] ? ~carry_reg : carry_reg;
            c_bit = a_sh_reg[0] ? carry_reg : 1'b0;
        end
    end

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = s_bit;
        end else begin : g_res_wn
            assign res_next = {s_bit, res_reg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= b_load;
                        carry_reg <= carry_load;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    res_reg   <= res_next;
                    carry_reg <= c_bit;
                    count_reg <= count_reg + 1'b1;
                    if (last_bit) begin
                        // carry_reg here is the carry into the MSB, c_bit the carry out of it.
                        sum_reg   <= res_next;
                        cout_reg  <= c_bit;
`ifdef SERIAL_ADDER_SUB_EN
                        ovf_reg   <= carry_reg ^ c_bit;
`endif
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_mux.sv
// Directed test of serial_adder_mux against a cycle-level arithmetic model;
// sub/ovf cases are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_mux;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   check_en = 1'b0;

    serial_adder_mux_if #(.WIDTH(W)) bus ();

    serial_adder_mux #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: an accepted op at edge e is busy for cycles e..e+W-1, done at cycle e+W.
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_sum    = 0;
    int m_cout   = 0;
    int m_ovf    = 0;
    int p_sum    = 0;
    int p_cout   = 0;
    int p_ovf    = 0;

    always @(negedge clk) begin
        bit e_busy;
        bit e_done;
        bit is_sub;
        int bo;
        int ci;
        int sa;
        int sb;
        int sr;
        int t;
        if (m_active && cyc == m_start + W) begin
            m_sum  = p_sum;
            m_cout = p_cout;
            m_ovf  = p_ovf;
        end
        e_busy = m_active && cyc >= m_start && cyc < m_start + W;
        e_done = m_active && cyc == m_start + W;
        if (check_en) begin
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("done", int'(bus.done), int'(e_done));
            chk("sum",  int'(bus.sum),  m_sum);
            chk("cout", int'(bus.cout), m_cout);
`ifdef SERIAL_ADDER_SUB_EN
            chk("ovf",  int'(bus.ovf),  m_ovf);
`endif
        end
        if (rst) begin
            m_active = 1'b0;
            m_sum    = 0;
            m_cout   = 0;
            m_ovf    = 0;
        end else if (bus.start && !e_busy) begin
`ifdef SERIAL_ADDER_SUB_EN
            is_sub = bus.sub;
`else
            is_sub = 1'b0;
`endif
            bo = is_sub ? (MASK - int'(bus.b)) : int'(bus.b);
            ci = is_sub ? 1 : int'(bus.cin);
            t  = int'(bus.a) + bo + ci;
            sa = (int'(bus.a) >= (1 << (W - 1))) ? int'(bus.a) - (1 << W) : int'(bus.a);
            sb = (int'(bus.b) >= (1 << (W - 1))) ? int'(bus.b) - (1 << W) : int'(bus.b);
            sr = is_sub ? sa - sb : sa + sb + int'(bus.cin);
            p_sum    = t & MASK;
            p_cout   = (t >> W) & 1;
            p_ovf    = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
            m_active = 1'b1;
            m_start  = cyc + 1;
        end
    end

    task automatic set_ops(input int a, input int b, input int cin, input int sub);
        bus.a   = a[W-1:0];
        bus.b   = b[W-1:0];
        bus.cin = cin[0];
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub[0];
`else
        if (sub != 0) $display("note: sub requested but not built in");
`endif
    endtask

    // Pulses start for one edge; returns 2 time units after the accepting edge.
    task automatic go(input int a, input int b, input int cin, input int sub);
        @(posedge clk); #2;
        set_ops(a, b, cin, sub);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no done within 30 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic op(input string name, input int a, input int b, input int cin, input int sub,
                      input int es, input int ec);
        int lat;
        go(a, b, cin, sub);
        wait_done(lat);
        chk({name, "_latency"}, lat, W + 1);
        chk({name, "_sum"}, int'(bus.sum), es);
        chk({name, "_cout"}, int'(bus.cout), ec);
        $display("op %s: a=0x%02h b=0x%02h cin=%0d sub=%0d -> sum=0x%02h cout=%0d", name, a, b,
                 cin, sub, bus.sum, bus.cout);
    endtask

    initial begin
        int lat;
        bus.start = 1'b0;
        set_ops(0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_sum",  int'(bus.sum),  0);
        chk("reset_cout", int'(bus.cout), 0);

        op("add_5a_3c", 'h5A, 'h3C, 0, 0, 'h96, 0);
        op("add_ff_01", 'hFF, 'h01, 0, 0, 'h00, 1);
        op("add_ff_ff_c", 'hFF, 'hFF, 1, 0, 'hFF, 1);

        // Start during RUN is ignored; start in the done cycle is accepted.
        go('h10, 'h20, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        set_ops('h00, 'h00, 0, 0);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        set_ops('h01, 'h02, 0, 0);
        bus.start = 1'b1;
        @(negedge clk);
        chk("ignored_done", int'(bus.done), 1);
        chk("ignored_sum",  int'(bus.sum),  'h30);
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(lat);
        chk("b2b_latency", lat, W + 1);
        chk("b2b_sum",     int'(bus.sum), 'h03);
        $display("op b2b: a=0x01 b=0x02 -> sum=0x%02h cout=%0d", bus.sum, bus.cout);

        // Reset on the 4th RUN cycle aborts the operation.
        go('h55, 'h11, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_sum",  int'(bus.sum),  0);
        chk("abort_done", int'(bus.done), 0);
        repeat (12) @(negedge clk);
        $display("op abort: a=0x55 b=0x11 reset mid-run -> sum=0x%02h", bus.sum);
        op("add_11_22", 'h11, 'h22, 0, 0, 'h33, 0);
        op("add_80_80", 'h80, 'h80, 1, 0, 'h01, 1);

`ifdef SERIAL_ADDER_SUB_EN
        op("sub_10_20", 'h10, 'h20, 0, 1, 'hF0, 0);
        chk("sub_10_20_ovf", int'(bus.ovf), 0);
        op("sub_80_01", 'h80, 'h01, 1, 1, 'h7F, 1);
        chk("sub_80_01_ovf", int'(bus.ovf), 1);
        op("add_7f_01", 'h7F, 'h01, 0, 0, 'h80, 0);
        chk("add_7f_01_ovf", int'(bus.ovf), 1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
